// File: rtl/sargantana_itag_lookup.sv
// Instruction-cache tag store with one-cycle lookup, round-robin victim selection and a sequential flush engine.
// Optional per-way tag parity is enabled by defining ITAG_PARITY_EN.
module sargantana_itag_lookup #(
    parameter int ICACHE_N_WAY   = 4,
    parameter int TAG_DEPTH      = 64,
    parameter int TAG_ADDR_WIDHT = $clog2(TAG_DEPTH),
    parameter int TAG_WIDHT      = 20
) (
    input  logic                              clk_i,
    input  logic                              rstn_i,
    input  logic                              req_valid_i,
    output logic                              req_ready_o,
    input  logic                              we_i,
    input  logic [ICACHE_N_WAY-1:0]           way_i,
    input  logic [TAG_ADDR_WIDHT-1:0]         addr_i,
    input  logic [TAG_WIDHT-1:0]              data_i,
    input  logic                              vbit_i,
    input  logic [TAG_WIDHT-1:0]              cmp_tag_i,
    input  logic                              flush_i,
    output logic                              rsp_valid_o,
    output logic                              hit_o,
    output logic [ICACHE_N_WAY-1:0]           hit_way_o,
    output logic [ICACHE_N_WAY*TAG_WIDHT-1:0] tag_way_o,
    output logic [ICACHE_N_WAY-1:0]           vbit_o,
    output logic [ICACHE_N_WAY-1:0]           repl_way_o,
    output logic                              flush_busy_o,
    output logic                              parity_err_o
);

    localparam int PTR_W = $clog2(ICACHE_N_WAY);

    typedef enum logic {FLUSH, IDLE} state_t;

    state_t                      state_q, state_d;
    logic [TAG_ADDR_WIDHT-1:0]   idx_q, idx_d;

    logic [TAG_WIDHT-1:0]        tag_mem  [TAG_DEPTH][ICACHE_N_WAY];
    logic [ICACHE_N_WAY-1:0]     vbit_mem [TAG_DEPTH];
    logic [PTR_W-1:0]            rr_mem   [TAG_DEPTH];
`ifdef ITAG_PARITY_EN
    logic [ICACHE_N_WAY-1:0]     par_mem  [TAG_DEPTH];
    logic [ICACHE_N_WAY-1:0]     perr_p0;
`endif

    logic                              req_acc, wr_en, rd_en;
    logic [ICACHE_N_WAY-1:0]           hit_p0, vbit_p0, repl_p0;
    logic [ICACHE_N_WAY*TAG_WIDHT-1:0] tag_p0;

    logic                              vld_p1, perr_p1;
    logic [ICACHE_N_WAY-1:0]           hit_p1, vbit_p1, repl_p1;
    logic [ICACHE_N_WAY*TAG_WIDHT-1:0] tag_p1;

    // Victim: lowest-index invalid way, otherwise the round-robin way.
    function automatic logic [ICACHE_N_WAY-1:0] pick_victim(
        input logic [ICACHE_N_WAY-1:0] vld,
        input logic [PTR_W-1:0]        ptr
    );
        logic [ICACHE_N_WAY-1:0] sel;
        logic                    found;
        sel   = '0;
        found = 1'b0;
        for (int w = 0; w < ICACHE_N_WAY; w++) begin
            if (!vld[w] && !found) begin
                sel[w] = 1'b1;
                found  = 1'b1;
            end
        end
        if (!found) sel[ptr] = 1'b1;
        return sel;
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            FLUSH: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == TAG_ADDR_WIDHT'(TAG_DEPTH - 1)) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            end
            IDLE: begin
                if (flush_i) begin
                    state_d = FLUSH;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = FLUSH;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= FLUSH;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    assign flush_busy_o = (state_q == FLUSH);
    assign req_ready_o  = !flush_busy_o && !flush_i;
    assign req_acc      = req_valid_i && req_ready_o;
    assign wr_en        = req_acc && we_i;
    assign rd_en        = req_acc && !we_i;

    // Storage: the flush engine owns the valid bits and pointers while busy.
    always_ff @(posedge clk_i) begin
        if (flush_busy_o) begin
            vbit_mem[idx_q] <= '0;
            rr_mem[idx_q]   <= '0;
        end else if (wr_en) begin
            for (int w = 0; w < ICACHE_N_WAY; w++) begin
                if (way_i[w]) begin
                    tag_mem[addr_i][w]  <= data_i;
                    vbit_mem[addr_i][w] <= vbit_i;
`ifdef ITAG_PARITY_EN
                    par_mem[addr_i][w]  <= ^data_i;
`endif
                end
            end
            if (vbit_i) rr_mem[addr_i] <= rr_mem[addr_i] + 1'b1;
        end
    end

    // Stage p0: combinational compare against the addressed set.
    always_comb begin
        vbit_p0 = vbit_mem[addr_i];
        hit_p0  = '0;
        tag_p0  = '0;
`ifdef ITAG_PARITY_EN
        perr_p0 = '0;
`endif
        for (int w = 0; w < ICACHE_N_WAY; w++) begin
            tag_p0[w*TAG_WIDHT +: TAG_WIDHT] = tag_mem[addr_i][w];
            hit_p0[w] = vbit_p0[w] && (tag_mem[addr_i][w] == cmp_tag_i);
`ifdef ITAG_PARITY_EN
            perr_p0[w] = vbit_p0[w] && ((^tag_mem[addr_i][w]) != par_mem[addr_i][w]);
            if (perr_p0[w]) hit_p0[w] = 1'b0;
`endif
        end
        repl_p0 = pick_victim(vbit_p0, rr_mem[addr_i]);
    end

    // Stage p1: response registers, held until the next lookup.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            vld_p1  <= 1'b0;
            hit_p1  <= '0;
            tag_p1  <= '0;
            vbit_p1 <= '0;
            repl_p1 <= '0;
            perr_p1 <= 1'b0;
        end else begin
            vld_p1 <= rd_en;
            if (rd_en) begin
                hit_p1  <= hit_p0;
                tag_p1  <= tag_p0;
                vbit_p1 <= vbit_p0;
                repl_p1 <= repl_p0;
`ifdef ITAG_PARITY_EN
                perr_p1 <= |perr_p0;
`else
                perr_p1 <= 1'b0;
`endif
            end
        end
    end

    assign rsp_valid_o  = vld_p1;
    assign hit_way_o    = hit_p1;
    assign hit_o        = |hit_p1;
    assign tag_way_o    = tag_p1;
    assign vbit_o       = vbit_p1;
    assign repl_way_o   = repl_p1;
`ifdef ITAG_PARITY_EN
    assign parity_err_o = perr_p1;
`else
    assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_sargantana_itag_lookup.sv
// Bench for sargantana_itag_lookup: directed vector table, flush/reset sequences and randomized ops against a set-level model.
module tb_sargantana_itag_lookup;

    localparam int NW = 4, DEPTH = 64, AW = 6, TW = 20;

    logic            clk, rstn;
    logic            req_valid, req_ready, we, vbit_in, flush, rsp_valid, hit;
    logic [NW-1:0]   way, hit_way, vbit_out, repl_way;
    logic [AW-1:0]   addr;
    logic [TW-1:0]   data, cmp_tag;
    logic [NW*TW-1:0] tag_way;
    logic            flush_busy, parity_err;

    sargantana_itag_lookup #(.ICACHE_N_WAY(NW), .TAG_DEPTH(DEPTH), .TAG_WIDHT(TW)) dut (
        .clk_i(clk), .rstn_i(rstn), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .we_i(we), .way_i(way), .addr_i(addr), .data_i(data), .vbit_i(vbit_in),
        .cmp_tag_i(cmp_tag), .flush_i(flush), .rsp_valid_o(rsp_valid), .hit_o(hit),
        .hit_way_o(hit_way), .tag_way_o(tag_way), .vbit_o(vbit_out), .repl_way_o(repl_way),
        .flush_busy_o(flush_busy), .parity_err_o(parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    // Set-level model: valid bits, known tags and a per-set write counter for round robin.
    bit [NW-1:0]   m_v     [DEPTH];
    logic [TW-1:0] m_tag   [DEPTH][NW];
    bit            m_known [DEPTH][NW];
    int            m_ptr   [DEPTH];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NW-1:0] model_victim(input int a);
        for (int w = 0; w < NW; w++)
            if (!m_v[a][w]) return NW'(1) << w;
        return NW'(1) << (m_ptr[a] % NW);
    endfunction

    task automatic model_flush();
        for (int s = 0; s < DEPTH; s++) begin
            m_v[s]   = '0;
            m_ptr[s] = 0;
        end
    endtask

    // Called at a negedge; issues one request and checks at the following negedge.
    task automatic do_op(input bit w_en, input logic [NW-1:0] w_way, input int a,
                         input logic [TW-1:0] w_data, input bit w_vb, input logic [TW-1:0] cmp);
        logic [NW-1:0] eh, ev, er;
        req_valid = 1'b1; we = w_en; way = w_way; addr = a[AW-1:0];
        data = w_data; vbit_in = w_vb; cmp_tag = cmp;
        #1;
        chk("req_ready", req_ready, 1);
        ev = m_v[a];
        for (int w = 0; w < NW; w++) eh[w] = ev[w] && (m_tag[a][w] == cmp);
        er = model_victim(a);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        if (w_en) begin
            chk("wr_no_rsp", rsp_valid, 0);
            for (int w = 0; w < NW; w++)
                if (w_way[w]) begin
                    m_tag[a][w] = w_data; m_known[a][w] = 1'b1; m_v[a][w] = w_vb;
                end
            if (w_vb) m_ptr[a] = (m_ptr[a] + 1) % NW;
        end else begin
            chk("rsp_valid", rsp_valid, 1);
            chk("hit_way", hit_way, eh);
            chk("hit", hit, |eh);
            chk("vbit", vbit_out, ev);
            chk("repl_way", repl_way, er);
            chk("parity_err", parity_err, 0);
            for (int w = 0; w < NW; w++)
                if (m_known[a][w]) chk("tag_way", tag_way[w*TW +: TW], m_tag[a][w]);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"}, flush_busy, 1);
        chk({tag, "_ready"}, req_ready, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_hit"}, hit, 0);
        chk({tag, "_hit_way"}, hit_way, 0);
        chk({tag, "_tag_way"}, tag_way[63:0], 0);
        chk({tag, "_vbit"}, vbit_out, 0);
        chk({tag, "_repl"}, repl_way, 0);
        chk({tag, "_perr"}, parity_err, 0);
    endtask

    // Counts negedges with flush_busy high, starting at the current negedge.
    task automatic count_busy(output int n, input int pulse_at);
        n = 0;
        while (flush_busy && n < 200) begin
            flush = (n == pulse_at);
            n++;
            @(negedge clk);
        end
        flush = 1'b0;
    endtask

    typedef struct {
        bit            w_en;
        logic [NW-1:0] w_way;
        int            a;
        logic [TW-1:0] w_data;
        bit            w_vb;
        logic [TW-1:0] cmp;
        logic [NW-1:0] e_hit, e_vbit, e_repl;
        int            tw;
        logic [TW-1:0] e_tag;
    } vec_t;

    vec_t tbl [16];

    initial begin
        int n;
        tbl[0]  = '{1, 4'b0010, 3,  20'hABCDE, 1, 0,         0,       0,       0,       -1, 0};
        tbl[1]  = '{0, 4'b0000, 3,  0,         0, 20'hABCDE, 4'b0010, 4'b0010, 4'b0001, 1,  20'hABCDE};
        tbl[2]  = '{1, 4'b0001, 7,  20'h11,    1, 0,         0,       0,       0,       -1, 0};
        tbl[3]  = '{1, 4'b0010, 7,  20'h22,    1, 0,         0,       0,       0,       -1, 0};
        tbl[4]  = '{1, 4'b0100, 7,  20'h33,    1, 0,         0,       0,       0,       -1, 0};
        tbl[5]  = '{1, 4'b1000, 7,  20'h44,    1, 0,         0,       0,       0,       -1, 0};
        tbl[6]  = '{1, 4'b0100, 7,  20'h77,    1, 0,         0,       0,       0,       -1, 0};
        tbl[7]  = '{0, 4'b0000, 7,  0,         0, 20'h77,    4'b0100, 4'b1111, 4'b0010, 2,  20'h77};
        tbl[8]  = '{0, 4'b0000, 5,  0,         0, 20'h0,     4'b0000, 4'b0000, 4'b0001, -1, 0};
        tbl[9]  = '{1, 4'b0001, 9,  20'h00001, 1, 0,         0,       0,       0,       -1, 0};
        tbl[10] = '{0, 4'b0000, 9,  0,         0, 20'h00001, 4'b0001, 4'b0001, 4'b0010, 0,  20'h00001};
        tbl[11] = '{1, 4'b0011, 11, 20'h55,    1, 0,         0,       0,       0,       -1, 0};
        tbl[12] = '{0, 4'b0000, 11, 0,         0, 20'h55,    4'b0011, 4'b0011, 4'b0100, 1,  20'h55};
        tbl[13] = '{1, 4'b0010, 3,  20'hABCDE, 0, 0,         0,       0,       0,       -1, 0};
        tbl[14] = '{0, 4'b0000, 3,  0,         0, 20'hABCDE, 4'b0000, 4'b0000, 4'b0001, 1,  20'hABCDE};
        tbl[15] = '{0, 4'b0000, 7,  0,         0, 20'h11,    4'b0001, 4'b1111, 4'b0010, 0,  20'h11};

        for (int s = 0; s < DEPTH; s++)
            for (int w = 0; w < NW; w++) begin
                m_tag[s][w] = '0; m_known[s][w] = 1'b0;
            end
        model_flush();

        rstn = 1'b0; req_valid = 1'b0; we = 1'b0; way = '0; addr = '0;
        data = '0; vbit_in = 1'b0; cmp_tag = '0; flush = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");

        // Power-on flush while a lookup is held pending.
        rstn = 1'b1; req_valid = 1'b1; addr = 6'd5;
        n = 0;
        while (!req_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("init_flush_len", n, 64);
        chk("init_flush_no_rsp", rsp_valid, 0);
        model_flush();

        for (int i = 0; i < 16; i++) begin
            do_op(tbl[i].w_en, tbl[i].w_way, tbl[i].a, tbl[i].w_data, tbl[i].w_vb, tbl[i].cmp);
            if (!tbl[i].w_en) begin
                chk("tbl_hit_way", hit_way, tbl[i].e_hit);
                chk("tbl_hit", hit, |tbl[i].e_hit);
                chk("tbl_vbit", vbit_out, tbl[i].e_vbit);
                chk("tbl_repl", repl_way, tbl[i].e_repl);
                if (tbl[i].tw >= 0) chk("tbl_tag", tag_way[tbl[i].tw*TW +: TW], tbl[i].e_tag);
            end
        end

        // Response hold over an idle cycle.
        @(negedge clk);
        chk("hold_rsp_valid", rsp_valid, 0);
        chk("hold_hit_way", hit_way, 4'b0001);
        chk("hold_repl", repl_way, 4'b0010);

        // Flush concurrent with a request, one cycle after a lookup.
        do_op(0, 4'b0000, 7, 0, 0, 20'h77);
        chk("pre_flush_rsp_hit", hit_way, 4'b0100);
        flush = 1'b1; req_valid = 1'b1; we = 1'b0; addr = 6'd7; cmp_tag = 20'h77;
        #1 chk("flush_blocks_ready", req_ready, 0);
        @(posedge clk);
        #1 begin flush = 1'b0; req_valid = 1'b0; end
        @(negedge clk);
        chk("flush_req_dropped", rsp_valid, 0);
        count_busy(n, 10);
        chk("flush_len", n, 64);
        chk("post_flush_ready", req_ready, 1);
        model_flush();
        for (int s = 0; s < DEPTH; s++) begin
            do_op(0, 4'b0000, s, 0, 0, 20'h0);
            chk("post_flush_vbit", vbit_out, 0);
        end

        // Randomized ops on a few sets to force collisions and wrap.
        for (int i = 0; i < 400; i++) begin
            logic [NW-1:0] rw;
            rw = ($urandom % 8 == 0) ? NW'($urandom) : (NW'(1) << ($urandom % NW));
            do_op($urandom % 2 == 0, rw, $urandom % 8, TW'($urandom % 8),
                  ($urandom % 4) != 0, TW'($urandom % 8));
        end

        // Reset in the middle of a flush after a non-zero response.
        do_op(1, 4'b0100, 20, 20'hF0F0F, 1, 0);
        do_op(0, 4'b0000, 20, 0, 0, 20'hF0F0F);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        repeat (31) @(negedge clk);
        chk("mid_flush_busy", flush_busy, 1);
        rstn = 1'b0;
        #1 check_reset_vals("mid_flush_reset");
        @(negedge clk);
        rstn = 1'b1;
        count_busy(n, -1);
        chk("reflush_len", n, 64);
        model_flush();
        do_op(0, 4'b0000, 20, 0, 0, 20'hF0F0F);
        chk("reflush_vbit", vbit_out, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sargantana_itag_lookup.md
# sargantana_itag_lookup

Parametrised instruction-cache tag store with integrated lookup. It holds one tag and one valid bit per way and set. A read compares all ways against a request tag and returns a one-hot hit vector, the raw tags, the valid bits and a replacement victim, one cycle after the request. Valid bits are cleared by a sequential flush engine that runs after reset and on request. The block sits between the icache controller and the data array and replaces the plain tag memory.

## Interface
- ICACHE_N_WAY, 4, number of ways; power of two, at least 2
- TAG_DEPTH, 64, number of sets; power of two
- TAG_ADDR_WIDHT, $clog2(TAG_DEPTH), set index width
- TAG_WIDHT, 20, tag width
- clk_i  in  1  clock
- rstn_i  in  1  reset; asynchronous, active-low
- req_valid_i  in  1  request strobe; accepted when req_valid_i && req_ready_o
- req_ready_o  out  1  equals !flush_busy_o && !flush_i
- we_i  in  1  1 = write, 0 = lookup
- way_i  in  ICACHE_N_WAY  one-hot target way for writes
- addr_i  in  TAG_ADDR_WIDHT  set index
- data_i  in  TAG_WIDHT  tag to write
- vbit_i  in  1  valid bit to write
- cmp_tag_i  in  TAG_WIDHT  tag to compare on lookup
- flush_i  in  1  invalidate-all request; single-cycle pulse
- rsp_valid_o  out  1  lookup response strobe
- hit_o  out  1  OR of hit_way_o
- hit_way_o  out  ICACHE_N_WAY  per-way hit
- tag_way_o  out  ICACHE_N_WAY*TAG_WIDHT  stored tag per way
- vbit_o  out  ICACHE_N_WAY  stored valid per way
- repl_way_o  out  ICACHE_N_WAY  one-hot victim for the looked-up set
- flush_busy_o  out  1  flush engine active
- parity_err_o  out  1  parity error on the response; tied 0 without the macro

## Operation
- FSM states are FLUSH and IDLE, with a flush index counter of TAG_ADDR_WIDHT bits.
- **Reset:**
  - Asynchronous reset enters FLUSH with idx = 0.
  - Reset values: flush_busy_o = 1, req_ready_o = 0. rsp_valid_o, hit_o, hit_way_o, tag_way_o, vbit_o, repl_way_o and parity_err_o are all 0.
  - Tag contents are not reset.
- **FLUSH state:**
  - Each cycle clears the valid bits of all ways in set idx and zeroes that set's round-robin pointer.
  - After idx == TAG_DEPTH-1 the FSM goes to IDLE.
- **IDLE state:** flush_i moves the FSM to FLUSH with idx = 0. flush_i is ignored while already in FLUSH.
- **Write:**
  - The tag and valid bit are written for every way set in way_i at addr_i.
  - When vbit_i = 1, the set's round-robin pointer advances by 1 modulo ICACHE_N_WAY.
  - Writes produce no response.
- **Lookup:**
  - The set and cmp_tag_i are captured.
  - hit_way_o[w] = vbit[w] && (tag[w] == captured cmp_tag).
  - If several ways hit, all are reported and hit_o = 1.
- **Replacement:** repl_way_o is the lowest-index invalid way. If all ways are valid, it is the way selected by the set's round-robin pointer.
- **Output hold:** response outputs hold their values until the next response. rsp_valid_o is high for exactly one cycle per lookup.

## Timing
- A lookup accepted at cycle T produces its response at T+1. Back-to-back lookups give one response per cycle.
- A write accepted at T is visible to a lookup accepted at T+1 or later, including the round-robin pointer update.
- If flush_i arrives while a request is also presented, the flush wins: req_ready_o = 0 and the request is not accepted.
- A lookup accepted at T-1 still responds at T even if flush_i rises at T.
- Flush takes exactly TAG_DEPTH cycles. flush_busy_o falls, and req_ready_o rises, in the cycle after the last set is cleared.
- Asserting rstn_i mid-flush or mid-response aborts everything. The block restarts a full flush and drops any pending response.

## Configuration
- Macro: ITAG_PARITY_EN.
- **With the macro:**
  - Each way stores one extra bit, ^data_i, written with the tag.
  - On lookup, any way with vbit = 1 whose recomputed parity mismatches has its hit_way_o bit forced to 0.
  - That response reports parity_err_o = 1. vbit_o still reports the stored value.
- **Without the macro:** no parity storage, and parity_err_o is constant 0.

## Test plan
- Reset, then hold req_valid_i = 1: req_ready_o stays 0 for TAG_DEPTH cycles (64), then rises. A lookup of set 5 then returns vbit_o = 0000, hit_o = 0, repl_way_o = 0001.
- Write tag 0xABCDE to way 0010 in set 3, then look up set 3 with cmp 0xABCDE on the next cycle: at T+1, hit_way_o = 0010, hit_o = 1, tag_way_o[1] = 0xABCDE, repl_way_o = 0001.
- Fill all 4 ways of set 7 valid with 4 writes (pointer wraps to 0), then write way 0100 valid once more: a lookup returns repl_way_o = 0010 (pointer = 1).
- Pulse flush_i together with req_valid_i (lookup) one cycle after a preceding lookup: the earlier response appears, the concurrent request is not accepted, and flush_busy_o stays high for 64 cycles. Afterwards every set reads vbit_o = 0000.
- With ITAG_PARITY_EN, force-flip bit 0 of the stored tag in way 0 of set 9 (written valid 0x00001): a lookup with cmp 0x00001 gives hit_o = 0 and parity_err_o = 1. Without the macro it gives hit_o = 0 (tag mismatch) and parity_err_o = 0.
- Drop rstn_i during flush idx = 30: all outputs return to their reset values, and after release the flush runs a full 64 cycles again.
